// File: rtl/serial_add_arbiter_if.sv
// Bundle of the two requester channels, the result channel and the status flag
// of serial_add_arbiter; master drives requests and consumes results.
interface serial_add_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             Req0_valid;
  logic [WIDTH-1:0] Req0_A;
  logic [WIDTH-1:0] Req0_B;
  logic             Req0_Cin;
  logic             Req0_ready;
  logic             Req1_valid;
  logic [WIDTH-1:0] Req1_A;
  logic [WIDTH-1:0] Req1_B;
  logic             Req1_Cin;
  logic             Req1_ready;
  logic             Data_out_valid;
  logic [WIDTH-1:0] Data_out_Sum;
  logic             Data_out_Carry;
  logic             Data_out_Id;
  logic             Data_out_ready;
  logic             Busy;

  modport master (
    output Req0_valid, Req0_A, Req0_B, Req0_Cin,
    output Req1_valid, Req1_A, Req1_B, Req1_Cin,
    output Data_out_ready,
    input  Req0_ready, Req1_ready,
    input  Data_out_valid, Data_out_Sum, Data_out_Carry, Data_out_Id, Busy
  );

  modport slave (
    input  Req0_valid, Req0_A, Req0_B, Req0_Cin,
    input  Req1_valid, Req1_A, Req1_B, Req1_Cin,
    input  Data_out_ready,
    output Req0_ready, Req1_ready,
    output Data_out_valid, Data_out_Sum, Data_out_Carry, Data_out_Id, Busy
  );
endinterface

// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin arbiter in front of a bit-serial adder: one shared
// full adder produces one sum bit per SHIFT cycle, LSB first.
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Req0_valid,
  input  logic [WIDTH-1:0] Req0_A,
  input  logic [WIDTH-1:0] Req0_B,
  input  logic             Req0_Cin,
  output logic             Req0_ready,
  input  logic             Req1_valid,
  input  logic [WIDTH-1:0] Req1_A,
  input  logic [WIDTH-1:0] Req1_B,
  input  logic             Req1_Cin,
  output logic             Req1_ready,
  output logic             Data_out_valid,
  output logic [WIDTH-1:0] Data_out_Sum,
  output logic             Data_out_Carry,
  output logic             Data_out_Id,
  input  logic             Data_out_ready,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic             ptr_q;
  logic             id_q;
  logic             c_q;
  logic             valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;

  logic [1:0]       req_valid;
  logic [1:0]       req_cin;
  logic [WIDTH-1:0] req_a [2];
  logic [WIDTH-1:0] req_b [2];
  logic [1:0]       grant;
  logic             grant_id;
  logic             fa_s;
  logic             fa_c;

  assign req_valid = {Req1_valid, Req0_valid};
  assign req_cin   = {Req1_Cin, Req0_Cin};
  assign req_a[0]  = Req0_A;
  assign req_a[1]  = Req1_A;
  assign req_b[0]  = Req0_B;
  assign req_b[1]  = Req1_B;

  // A lone requester wins outright; the pointer only breaks ties.
  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant[gi] = (state_q == IDLE) && !rst && req_valid[gi] &&
                       (!req_valid[1-gi] || (ptr_q == 1'(gi)));
  end

  assign grant_id   = grant[1];
  assign Req0_ready = grant[0];
  assign Req1_ready = grant[1];

  assign fa_s = a_q[0] ^ b_q[0] ^ c_q;
  assign fa_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      c_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            a_q     <= req_a[grant_id];
            b_q     <= req_b[grant_id];
            c_q     <= req_cin[grant_id];
            id_q    <= grant_id;
            ptr_q   <= ~grant_id;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sum_q <= {fa_s, sum_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= fa_c;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (Data_out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Data_out_valid = valid_q;
  assign Data_out_Sum   = sum_q;
  assign Data_out_Carry = c_q;
  assign Data_out_Id    = id_q;
  assign Busy           = busy_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: an 8-bit instance driven from a vector table and
// corner-case sequences, and a 2-bit instance swept exhaustively.
module tb_serial_add_arbiter;

  logic clk = 1'b0;
  logic rst8;
  logic rst2;
  always #5 clk = ~clk;

  serial_add_arbiter_if #(.WIDTH(8)) b8 ();
  serial_add_arbiter_if #(.WIDTH(2)) b2 ();

  serial_add_arbiter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8),
    .Req0_valid(b8.Req0_valid), .Req0_A(b8.Req0_A), .Req0_B(b8.Req0_B),
    .Req0_Cin(b8.Req0_Cin), .Req0_ready(b8.Req0_ready),
    .Req1_valid(b8.Req1_valid), .Req1_A(b8.Req1_A), .Req1_B(b8.Req1_B),
    .Req1_Cin(b8.Req1_Cin), .Req1_ready(b8.Req1_ready),
    .Data_out_valid(b8.Data_out_valid), .Data_out_Sum(b8.Data_out_Sum),
    .Data_out_Carry(b8.Data_out_Carry), .Data_out_Id(b8.Data_out_Id),
    .Data_out_ready(b8.Data_out_ready), .Busy(b8.Busy)
  );

  serial_add_arbiter #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst2),
    .Req0_valid(b2.Req0_valid), .Req0_A(b2.Req0_A), .Req0_B(b2.Req0_B),
    .Req0_Cin(b2.Req0_Cin), .Req0_ready(b2.Req0_ready),
    .Req1_valid(b2.Req1_valid), .Req1_A(b2.Req1_A), .Req1_B(b2.Req1_B),
    .Req1_Cin(b2.Req1_Cin), .Req1_ready(b2.Req1_ready),
    .Data_out_valid(b2.Data_out_valid), .Data_out_Sum(b2.Data_out_Sum),
    .Data_out_Carry(b2.Data_out_Carry), .Data_out_Id(b2.Data_out_Id),
    .Data_out_ready(b2.Data_out_ready), .Busy(b2.Busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic id; logic carry; logic [7:0] sum;} res8_t;
  typedef struct packed {logic id; logic carry; logic [1:0] sum;} res2_t;

  res8_t q8[$];
  res2_t q2[$];
  int    grants8[$];
  int    hs8 = 0;
  logic  infl8 = 1'b0;
  logic  infl2 = 1'b0;

  // Scoreboards sample just before each rising edge, so what they see is what
  // that edge will act on.
  always begin
    logic [8:0] t8;
    logic [2:0] t2;
    res8_t      r8;
    res2_t      r2;
    @(negedge clk);
    #4;
    if (rst8) begin
      q8.delete();
      infl8 = 1'b0;
    end else begin
      check("busy8", b8.Busy, infl8);
      if (b8.Req0_ready || b8.Req1_ready)
        check("ready_excl8", b8.Req0_ready & b8.Req1_ready, 0);
      if (b8.Req0_valid && b8.Req0_ready) begin
        t8 = {1'b0, b8.Req0_A} + {1'b0, b8.Req0_B} + 9'(b8.Req0_Cin);
        q8.push_back({1'b0, t8[8], t8[7:0]});
        grants8.push_back(0);
        infl8 = 1'b1;
      end
      if (b8.Req1_valid && b8.Req1_ready) begin
        t8 = {1'b0, b8.Req1_A} + {1'b0, b8.Req1_B} + 9'(b8.Req1_Cin);
        q8.push_back({1'b1, t8[8], t8[7:0]});
        grants8.push_back(1);
        infl8 = 1'b1;
      end
      if (b8.Data_out_valid && b8.Data_out_ready) begin
        if (q8.size() == 0) begin
          check("sb8_unexpected", 1, 0);
        end else begin
          r8 = q8.pop_front();
          check("sb8_sum", b8.Data_out_Sum, r8.sum);
          check("sb8_carry", b8.Data_out_Carry, r8.carry);
          check("sb8_id", b8.Data_out_Id, r8.id);
        end
        hs8++;
        infl8 = 1'b0;
      end
    end
    if (rst2) begin
      q2.delete();
      infl2 = 1'b0;
    end else begin
      check("busy2", b2.Busy, infl2);
      if (b2.Req0_ready || b2.Req1_ready)
        check("ready_excl2", b2.Req0_ready & b2.Req1_ready, 0);
      if (b2.Req0_valid && b2.Req0_ready) begin
        t2 = {1'b0, b2.Req0_A} + {1'b0, b2.Req0_B} + 3'(b2.Req0_Cin);
        q2.push_back({1'b0, t2[2], t2[1:0]});
        infl2 = 1'b1;
      end
      if (b2.Req1_valid && b2.Req1_ready) begin
        t2 = {1'b0, b2.Req1_A} + {1'b0, b2.Req1_B} + 3'(b2.Req1_Cin);
        q2.push_back({1'b1, t2[2], t2[1:0]});
        infl2 = 1'b1;
      end
      if (b2.Data_out_valid && b2.Data_out_ready) begin
        if (q2.size() == 0) begin
          check("sb2_unexpected", 1, 0);
        end else begin
          r2 = q2.pop_front();
          check("sb2_sum", b2.Data_out_Sum, r2.sum);
          check("sb2_carry", b2.Data_out_Carry, r2.carry);
          check("sb2_id", b2.Data_out_Id, r2.id);
        end
        infl2 = 1'b0;
      end
    end
  end

  function automatic logic rdy8(bit id);
    return id ? b8.Req1_ready : b8.Req0_ready;
  endfunction

  task automatic drive8(bit id, logic v, logic [7:0] a, logic [7:0] b, logic cin);
    if (id) begin
      b8.Req1_valid = v; b8.Req1_A = a; b8.Req1_B = b; b8.Req1_Cin = cin;
    end else begin
      b8.Req0_valid = v; b8.Req0_A = a; b8.Req0_B = b; b8.Req0_Cin = cin;
    end
  endtask

  // Counts rising edges from just after the accepting edge until valid shows.
  task automatic wait_valid8(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (b8.Data_out_valid) break;
    end
  endtask

  task automatic handshake8();
    @(negedge clk);
    b8.Data_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b8.Data_out_ready = 1'b0;
  endtask

  task automatic run8(bit id, logic [7:0] a, logic [7:0] b, logic cin,
                      logic [7:0] es, logic ec);
    int k;
    int lat;
    @(negedge clk);
    drive8(id, 1'b1, a, b, cin);
    #1;
    k = 0;
    while (!rdy8(id) && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("grant8", rdy8(id), 1);
    @(posedge clk);
    @(negedge clk);
    drive8(id, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_valid8(lat);
    check("latency8", lat, 8);
    @(negedge clk);
    check("tbl_sum", b8.Data_out_Sum, es);
    check("tbl_carry", b8.Data_out_Carry, ec);
    check("tbl_id", b8.Data_out_Id, id);
    $display("op8 id=%0d A=%02h B=%02h Cin=%0d -> Sum=%02h Carry=%0d", id, a, b, cin,
             b8.Data_out_Sum, b8.Data_out_Carry);
    handshake8();
  endtask

  task automatic run2(bit id, logic [1:0] a, logic [1:0] b, logic cin);
    int         k;
    logic [2:0] t;
    t = {1'b0, a} + {1'b0, b} + 3'(cin);
    @(negedge clk);
    if (id) begin
      b2.Req1_valid = 1'b1; b2.Req1_A = a; b2.Req1_B = b; b2.Req1_Cin = cin;
    end else begin
      b2.Req0_valid = 1'b1; b2.Req0_A = a; b2.Req0_B = b; b2.Req0_Cin = cin;
    end
    #1;
    check("grant2", id ? b2.Req1_ready : b2.Req0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    b2.Req0_valid = 1'b0;
    b2.Req1_valid = 1'b0;
    k = 0;
    while (k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (b2.Data_out_valid) break;
    end
    check("latency2", k, 2);
    @(negedge clk);
    check("w2_sum", b2.Data_out_Sum, t[1:0]);
    check("w2_carry", b2.Data_out_Carry, t[2]);
    check("w2_id", b2.Data_out_Id, id);
    $display("op2 id=%0d A=%0d B=%0d Cin=%0d -> Sum=%0d Carry=%0d", id, a, b, cin,
             b2.Data_out_Sum, b2.Data_out_Carry);
    b2.Data_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b2.Data_out_ready = 1'b0;
  endtask

  typedef struct {
    bit         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       carry;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int k;
    int lat;
    logic hold_ok;
    tbl[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[1] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{1'b0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    tbl[5] = '{1'b1, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{1'b1, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst8 = 1'b1;
    rst2 = 1'b1;
    b8.Data_out_ready = 1'b0;
    b2.Data_out_ready = 1'b0;
    drive8(1'b0, 1'b1, 8'h01, 8'h02, 1'b0);
    drive8(1'b1, 1'b1, 8'h10, 8'h20, 1'b1);
    b2.Req0_valid = 1'b0; b2.Req0_A = '0; b2.Req0_B = '0; b2.Req0_Cin = 1'b0;
    b2.Req1_valid = 1'b0; b2.Req1_A = '0; b2.Req1_B = '0; b2.Req1_Cin = 1'b0;

    @(negedge clk);
    #1;
    check("rst_ready0", b8.Req0_ready, 0);
    check("rst_ready1", b8.Req1_ready, 0);
    @(negedge clk);
    check("rst_valid", b8.Data_out_valid, 0);
    check("rst_sum", b8.Data_out_Sum, 0);
    check("rst_carry", b8.Data_out_Carry, 0);
    check("rst_id", b8.Data_out_Id, 0);
    check("rst_busy", b8.Busy, 0);

    // Both requesters held valid from reset: strict alternation expected.
    b8.Data_out_ready = 1'b1;
    rst8 = 1'b0;
    rst2 = 1'b0;
    k = 0;
    while (hs8 < 4 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("rr_handshakes", hs8, 4);
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive8(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    b8.Data_out_ready = 1'b0;
    check("rr_grant_count", grants8.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants8.size()) begin
        check("rr_order", grants8[i], i % 2);
        $display("rr grant %0d -> requester %0d", i, grants8[i]);
      end
    end

    for (int i = 0; i < 8; i++)
      run8(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].carry);

    // Consumer stalls 5 cycles in DONE while both requesters knock.
    @(negedge clk);
    drive8(1'b0, 1'b1, 8'h3C, 8'h0C, 1'b1);
    #1;
    check("stall_grant", b8.Req0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_valid8(lat);
    check("stall_latency", lat, 8);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      drive8(1'b0, 1'b1, 8'hA5, 8'h5A, 1'b1);
      drive8(1'b1, 1'b1, 8'hC3, 8'h3C, 1'b0);
      #1;
      check("stall_valid", b8.Data_out_valid, 1);
      check("stall_sum", b8.Data_out_Sum, 8'h49);
      check("stall_carry", b8.Data_out_Carry, 0);
      check("stall_id", b8.Data_out_Id, 0);
      check("stall_readies", {b8.Req1_ready, b8.Req0_ready}, 0);
    end
    @(negedge clk);
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive8(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    b8.Data_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_busy", b8.Busy, 0);
    check("stall_release_valid", b8.Data_out_valid, 0);
    $display("stall release: Busy=%0d valid=%0d", b8.Busy, b8.Data_out_valid);
    @(negedge clk);
    b8.Data_out_ready = 1'b0;

    // Reset lands on the third SHIFT cycle of a requester-0 operation.
    @(negedge clk);
    drive8(1'b0, 1'b1, 8'hAA, 8'h55, 1'b0);
    #1;
    check("abort_grant", b8.Req0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst8 = 1'b0;
    check("abort_busy", b8.Busy, 0);
    check("abort_valid", b8.Data_out_valid, 0);
    hold_ok = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (b8.Data_out_valid) hold_ok = 1'b0;
    end
    check("abort_no_result", hold_ok, 1);
    drive8(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
    drive8(1'b1, 1'b1, 8'h40, 8'h40, 1'b0);
    #1;
    check("abort_ptr_ready0", b8.Req0_ready, 1);
    check("abort_ptr_ready1", b8.Req1_ready, 0);
    @(posedge clk);
    @(negedge clk);
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive8(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_valid8(lat);
    check("post_abort_latency", lat, 8);
    @(negedge clk);
    check("post_abort_sum", b8.Data_out_Sum, 8'h02);
    check("post_abort_carry", b8.Data_out_Carry, 0);
    check("post_abort_id", b8.Data_out_Id, 0);
    $display("post-abort op: Sum=%02h Id=%0d", b8.Data_out_Sum, b8.Data_out_Id);
    handshake8();

    for (int i = 0; i < 32; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      run2(iv[0] ^ iv[1] ^ iv[2] ^ iv[3] ^ iv[4] ? 1'b1 : 1'b0, iv[4:3], iv[2:1], iv[0]);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
